// File: rtl/l2_types_pkg.sv
// rtl/l2_types_pkg.sv - shared types and constants for the L2 cache controller
package l2_types_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } l2_ctrl_state_t;

  localparam int NUM_WAYS = 4;

endpackage

// File: rtl/l2_cache_control_if.sv
// rtl/l2_cache_control_if.sv - L1-side, physical-memory and datapath-enable handshake bundle
interface l2_cache_control_if;

  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic hit_any;
  logic victim_dirty;
  logic idling;
  logic alloc;
  logic writeback;
  logic lru_load;
  logic pmem_read;
  logic pmem_write;
  logic pmem_resp;

  modport master (
    input  mem_read, mem_write, hit_any, victim_dirty, pmem_resp,
    output mem_resp, idling, alloc, writeback, lru_load, pmem_read, pmem_write
  );

  modport slave (
    output mem_read, mem_write, hit_any, victim_dirty, pmem_resp,
    input  mem_resp, idling, alloc, writeback, lru_load, pmem_read, pmem_write
  );

endinterface

// File: rtl/l2_cache_control_sat_counter.sv
// rtl/l2_cache_control_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/l2_cache_control.sv
// rtl/l2_cache_control.sv - L2 miss/writeback/refill sequencer with hit and miss counters
module l2_cache_control
  import l2_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  l2_cache_control_if.master  bus,
  input  logic                clear_counts,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count
);

  l2_ctrl_state_t state, state_next;
  logic refill, refill_next;
  logic req;
  logic hit_inc, miss_inc;

  assign req = bus.mem_read | bus.mem_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      refill <= 1'b0;
    end else begin
      state  <= state_next;
      refill <= refill_next;
    end
  end

  // refill marks the re-lookup after a fill so it is not counted as a first-lookup hit
  always_comb begin
    state_next  = state;
    refill_next = refill;
    case (state)
      IDLE: begin
        refill_next = 1'b0;
        if (req && !bus.hit_any) begin
          state_next = bus.victim_dirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (bus.pmem_resp) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        if (bus.pmem_resp) begin
          state_next  = IDLE;
          refill_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.idling     = 1'b0;
    bus.writeback  = 1'b0;
    bus.alloc      = 1'b0;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.mem_resp   = 1'b0;
    bus.lru_load   = 1'b0;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    case (state)
      IDLE: begin
        bus.idling   = 1'b1;
        bus.mem_resp = req & bus.hit_any & ~rst;
        bus.lru_load = req & bus.hit_any & ~rst;
        hit_inc      = req & bus.hit_any & ~refill;
        miss_inc     = req & ~bus.hit_any;
      end
      WRITEBACK: begin
        bus.writeback  = 1'b1;
        bus.pmem_write = 1'b1;
      end
      ALLOCATE: begin
        bus.alloc     = 1'b1;
        bus.pmem_read = 1'b1;
      end
      default: bus.idling = 1'b1;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .clr   (clear_counts),
    .count (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .clr   (clear_counts),
    .count (miss_count)
  );

endmodule

// File: tb/tb_l2_cache_control.sv
// tb/tb_l2_cache_control.sv - self-checking bench for l2_cache_control
module tb_l2_cache_control;

  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear_counts = 1'b0;
  logic [CW-1:0] hit_count, miss_count;
  int            n_chk = 0;
  int            n_bad = 0;

  l2_cache_control_if bus ();

  l2_cache_control #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.master),
    .clear_counts (clear_counts),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 = servicing lookups, 1 = writing victim back, 2 = filling line
  int  m_phase;
  bit  m_refill;
  int  m_hit, m_miss;
  logic m_req;

  assign m_req = bus.mem_read | bus.mem_write;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase  <= 0;
      m_refill <= 1'b0;
      m_hit    <= 0;
      m_miss   <= 0;
    end else begin
      if (clear_counts) begin
        m_hit  <= 0;
        m_miss <= 0;
      end else if (m_phase == 0 && m_req) begin
        if (bus.hit_any && !m_refill && m_hit < MAX) m_hit <= m_hit + 1;
        if (!bus.hit_any && m_miss < MAX) m_miss <= m_miss + 1;
      end
      if (m_phase == 0) begin
        m_refill <= 1'b0;
        if (m_req && !bus.hit_any) m_phase <= bus.victim_dirty ? 1 : 2;
      end else if (bus.pmem_resp) begin
        if (m_phase == 1) m_phase <= 2;
        else begin
          m_phase  <= 0;
          m_refill <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic serve;
    serve = !rst && m_phase == 0 && m_req && bus.hit_any;
    chk("idling",     bus.idling,     m_phase == 0);
    chk("writeback",  bus.writeback,  m_phase == 1);
    chk("alloc",      bus.alloc,      m_phase == 2);
    chk("pmem_write", bus.pmem_write, m_phase == 1);
    chk("pmem_read",  bus.pmem_read,  m_phase == 2);
    chk("mem_resp",   bus.mem_resp,   serve);
    chk("lru_load",   bus.lru_load,   serve);
    chk("hit_count",  hit_count,      m_hit);
    chk("miss_count", miss_count,     m_miss);
    chk("pmem_excl",  bus.pmem_read & bus.pmem_write, 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic rd, input logic wr, input logic hit, input logic dirty);
    bus.mem_read     = rd;
    bus.mem_write    = wr;
    bus.hit_any      = hit;
    bus.victim_dirty = dirty;
  endtask

  task automatic pulse_resp();
    bus.pmem_resp = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
  endtask

  initial begin
    set_req(0, 0, 0, 0);
    bus.pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_idling", bus.idling, 1);
    chk("rst_pmem_read", bus.pmem_read, 0);
    chk("rst_hit_count", hit_count, 0);
    rst = 1'b0;
    tick();

    // Hit with zero latency
    set_req(1, 0, 1, 0);
    #1;
    chk("hit_mem_resp", bus.mem_resp, 1);
    chk("hit_lru_load", bus.lru_load, 1);
    tick();
    set_req(0, 0, 0, 0);
    chk("hit_count_1", hit_count, 1);
    chk("hit_stay_idle", bus.idling, 1);
    tick();

    // Clean miss, fill after 5 cycles, re-lookup hit not counted
    set_req(1, 0, 0, 0);
    tick();
    chk("clean_pmem_read", bus.pmem_read, 1);
    chk("clean_alloc", bus.alloc, 1);
    repeat (4) tick();
    pulse_resp();
    bus.hit_any = 1'b1;
    #1;
    chk("clean_refill_resp", bus.mem_resp, 1);
    tick();
    set_req(0, 0, 0, 0);
    chk("clean_miss_count", miss_count, 1);
    chk("clean_hit_count", hit_count, 1);
    tick();

    // Dirty miss through writeback then allocate
    set_req(0, 1, 0, 1);
    tick();
    chk("dirty_pmem_write", bus.pmem_write, 1);
    chk("dirty_writeback", bus.writeback, 1);
    repeat (2) tick();
    pulse_resp();
    chk("dirty_alloc_read", bus.pmem_read, 1);
    chk("dirty_alloc_nowrite", bus.pmem_write, 0);
    tick();
    pulse_resp();
    bus.hit_any = 1'b1;
    #1;
    chk("dirty_refill_resp", bus.mem_resp, 1);
    tick();
    set_req(0, 0, 0, 0);
    chk("dirty_miss_count", miss_count, 2);
    tick();

    // Request withdrawn during writeback; refill clears after one idle cycle
    set_req(1, 0, 0, 1);
    tick();
    set_req(0, 0, 0, 0);
    tick();
    chk("drop_still_wb", bus.writeback, 1);
    pulse_resp();
    chk("drop_alloc", bus.alloc, 1);
    pulse_resp();
    chk("drop_no_resp", bus.mem_resp, 0);
    chk("drop_idle", bus.idling, 1);
    tick();
    set_req(1, 0, 1, 0);
    tick();
    set_req(0, 0, 0, 0);
    chk("drop_hit_counted", hit_count, 2);
    chk("drop_miss_count", miss_count, 3);
    tick();

    // Reset in the middle of allocate, then a stray pmem_resp
    set_req(1, 0, 0, 0);
    tick();
    chk("rstmid_pre_alloc", bus.alloc, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_pmem_read", bus.pmem_read, 0);
    chk("rstmid_alloc", bus.alloc, 0);
    chk("rstmid_idling", bus.idling, 1);
    chk("rstmid_hits", hit_count, 0);
    chk("rstmid_misses", miss_count, 0);
    set_req(0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    pulse_resp();
    chk("stray_idle", bus.idling, 1);
    chk("stray_no_read", bus.pmem_read, 0);
    chk("stray_no_write", bus.pmem_write, 0);

    // Saturation and clear priority
    set_req(1, 0, 1, 0);
    repeat (MAX) tick();
    chk("sat_full", hit_count, MAX);
    tick();
    chk("sat_hold", hit_count, MAX);
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    set_req(0, 0, 0, 0);
    chk("clear_wins", hit_count, 0);
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
